// File: rtl/microwave_cook_ctrl.sv
// Cooking-cycle sequencer for the BCD MM:SS countdown timer: keypad entry, load, 1 s tick, door/start/stop, done beep.
// Optional quick start / add-30-seconds on the start key is enabled by defining QUICK_START_EN.
module microwave_cook_ctrl #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int BEEP_CYCLES = 3
) (
  input  logic        clock,
  input  logic        clrn,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start,
  input  logic        stop,
  input  logic        door_closed,
  input  logic        timer_zero,
  output logic [15:0] timer_data,
  output logic        timer_loadn,
  output logic        timer_clrn,
  output logic        timer_enable,
  output logic        magnetron_on,
  output logic        beep,
  output logic [2:0]  state_o
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BEEP_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [PW-1:0] PRESC_ZERO = PW'(0);
  localparam logic [BW-1:0] BEEP_LAST  = BW'(BEEP_CYCLES - 1);
  localparam logic [BW-1:0] BEEP_ONE   = BW'(1);
  localparam logic [BW-1:0] BEEP_ZERO  = BW'(0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_LOAD  = 3'd2,
    S_COOK  = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        state_r, state_s;
  logic [15:0]   digits_r, digits_s;
  logic [PW-1:0] presc_r, presc_s;
  logic [BW-1:0] beeps_r, beeps_s;
  logic          tick_s, clr_s;
  logic [15:0]   data_r;
  logic          loadn_r, clrn_r, enable_r, magnetron_r, beep_r;

  // The timer cannot hold more than 59 seconds, so sec_tens above 5 is presented as 5.
  function automatic logic [15:0] sat_secs(input logic [15:0] d);
    logic [15:0] s;
    s = d;
    if (d[7:4] > 4'd5) begin
      s[7:4] = 4'd5;
    end else begin
      s[7:4] = d[7:4];
    end
    return s;
  endfunction

`ifdef QUICK_START_EN
  function automatic logic [15:0] add_30s(input logic [15:0] d);
    logic [15:0] s;
    logic [3:0]  st;
    s  = sat_secs(d);
    st = s[7:4] + 4'd3;
    if (st < 4'd6) begin
      s[7:4] = st;
    end else if (s[15:8] == 8'h99) begin
      s = 16'h9959;
    end else begin
      s[7:4] = st - 4'd6;
      if (s[11:8] == 4'd9) begin
        s[11:8]  = 4'd0;
        s[15:12] = s[15:12] + 4'd1;
      end else begin
        s[11:8] = s[11:8] + 4'd1;
      end
    end
    return s;
  endfunction
`endif

  // Next-state, digit register, prescaler and beep counter; stop > start > key_valid everywhere.
  always_comb begin
    state_s  = state_r;
    digits_s = digits_r;
    presc_s  = presc_r;
    beeps_s  = beeps_r;
    tick_s   = 1'b0;
    clr_s    = 1'b0;
    case (state_r)
      S_IDLE, S_ENTRY: begin
        if (stop) begin
          state_s  = S_IDLE;
          digits_s = 16'h0000;
        end else if (start) begin
          if (door_closed && (state_r == S_ENTRY) && (digits_r != 16'h0000)) begin
            state_s = S_LOAD;
            presc_s = PRESC_ZERO;
          end
`ifdef QUICK_START_EN
          else if (door_closed && (digits_r == 16'h0000)) begin
            state_s  = S_LOAD;
            digits_s = 16'h0030;
            presc_s  = PRESC_ZERO;
          end
`endif
          else begin
            state_s = state_r;
          end
        end else if (key_valid && (key_digit <= 4'd9)) begin
          state_s  = S_ENTRY;
          digits_s = {digits_r[11:0], key_digit};
        end else begin
          state_s = state_r;
        end
      end
      S_LOAD: begin
        state_s = S_COOK;
      end
      S_COOK: begin
        if (!door_closed) begin
          state_s = S_PAUSE;
        end else if (stop) begin
          state_s = S_PAUSE;
        end else if (timer_zero) begin
          state_s = S_DONE;
          presc_s = PRESC_ZERO;
          beeps_s = BEEP_ZERO;
        end
`ifdef QUICK_START_EN
        else if (start) begin
          state_s  = S_LOAD;
          digits_s = add_30s(digits_r);
        end
`endif
        else if (presc_r == PRESC_LAST) begin
          presc_s = PRESC_ZERO;
          tick_s  = 1'b1;
        end else begin
          presc_s = presc_r + PRESC_ONE;
        end
      end
      S_PAUSE: begin
        if (stop) begin
          state_s  = S_IDLE;
          digits_s = 16'h0000;
          clr_s    = 1'b1;
        end else if (start && door_closed) begin
          state_s = S_COOK;
        end else begin
          state_s = S_PAUSE;
        end
      end
      S_DONE: begin
        if (stop || key_valid || !door_closed) begin
          state_s  = S_IDLE;
          digits_s = 16'h0000;
        end else if (presc_r == PRESC_LAST) begin
          presc_s = PRESC_ZERO;
          if (beeps_r == BEEP_LAST) begin
            state_s  = S_IDLE;
            digits_s = 16'h0000;
          end else begin
            beeps_s = beeps_r + BEEP_ONE;
          end
        end else begin
          presc_s = presc_r + PRESC_ONE;
        end
      end
      default: begin
        state_s  = S_IDLE;
        digits_s = 16'h0000;
      end
    endcase
  end

  // State, counters and Moore outputs registered from the next-state values.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_r     <= S_IDLE;
      digits_r    <= 16'h0000;
      presc_r     <= PRESC_ZERO;
      beeps_r     <= BEEP_ZERO;
      data_r      <= 16'h0000;
      loadn_r     <= 1'b1;
      clrn_r      <= 1'b1;
      enable_r    <= 1'b0;
      magnetron_r <= 1'b0;
      beep_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      digits_r    <= digits_s;
      presc_r     <= presc_s;
      beeps_r     <= beeps_s;
      data_r      <= sat_secs(digits_s);
      loadn_r     <= (state_s != S_LOAD);
      clrn_r      <= !clr_s;
      enable_r    <= tick_s;
      magnetron_r <= (state_s == S_COOK);
      beep_r      <= (state_s == S_DONE);
    end
  end

  assign timer_data   = data_r;
  assign timer_loadn  = loadn_r;
  assign timer_clrn   = clrn_r;
  assign timer_enable = enable_r;
  assign magnetron_on = magnetron_r;
  assign beep         = beep_r;
  assign state_o      = state_r;

endmodule

// File: tb/tb_microwave_cook_ctrl.sv
// Bench for microwave_cook_ctrl: directed scenarios then random strobes, checked every cycle against a
// seconds/cycles reference model; a small timer model closes the loop on timer_zero.
`timescale 1ns/1ps
module tb_microwave_cook_ctrl;
  localparam int TD = 4;
  localparam int BC = 3;
  localparam int IDLE = 0, ENTRY = 1, LOAD = 2, COOK = 3, PAUSE = 4, DONE = 5;

  logic        clock = 1'b0;
  logic        clrn;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        start;
  logic        stop;
  logic        door_closed;
  logic        timer_zero;
  logic [15:0] timer_data;
  logic        timer_loadn;
  logic        timer_clrn;
  logic        timer_enable;
  logic        magnetron_on;
  logic        beep;
  logic [2:0]  state_o;

  int errors;
  int checks;
  int m_state;
  int m_dig[4];
  int m_ph;
  int m_beeps;
  bit m_en;
  bit m_clr;
  int tmr;

  microwave_cook_ctrl #(.TICK_DIV(TD), .BEEP_CYCLES(BC)) dut (
    .clock(clock), .clrn(clrn), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop(stop), .door_closed(door_closed), .timer_zero(timer_zero),
    .timer_data(timer_data), .timer_loadn(timer_loadn), .timer_clrn(timer_clrn),
    .timer_enable(timer_enable), .magnetron_on(magnetron_on), .beep(beep), .state_o(state_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_data();
    int st;
    st = (m_dig[2] > 5) ? 5 : m_dig[2];
    return 16'(m_dig[0] * 4096 + m_dig[1] * 256 + st * 16 + m_dig[3]);
  endfunction

  function automatic int bcd_secs(input logic [15:0] d);
    return int'(d[15:12]) * 600 + int'(d[11:8]) * 60 + int'(d[7:4]) * 10 + int'(d[3:0]);
  endfunction

  function automatic bit reg_nonzero();
    return (m_dig[0] + m_dig[1] + m_dig[2] + m_dig[3]) != 0;
  endfunction

  task automatic model_reset();
    m_state = IDLE;
    m_dig   = '{0, 0, 0, 0};
    m_ph    = 0;
    m_beeps = 0;
    m_en    = 1'b0;
    m_clr   = 1'b0;
  endtask

  task automatic check_outputs();
    chk("state_o", 16'(state_o), 16'(m_state));
    chk("timer_data", timer_data, exp_data());
    chk("timer_loadn", 16'(timer_loadn), 16'(m_state != LOAD));
    chk("timer_clrn", 16'(timer_clrn), 16'(!m_clr));
    chk("timer_enable", 16'(timer_enable), 16'(m_en));
    chk("magnetron_on", 16'(magnetron_on), 16'(m_state == COOK));
    chk("beep", 16'(beep), 16'(m_state == DONE));
  endtask

  // One clock: model reacts to the current inputs, the timer to the DUT's current outputs.
  task automatic cycle();
    int ns, nph, nb, tnext, secs, mins;
    int nd[4];
    bit nen, nclr;
    ns = m_state; nph = m_ph; nb = m_beeps; nen = 1'b0; nclr = 1'b0; nd = m_dig;
    case (m_state)
      IDLE, ENTRY: begin
        if (stop) begin
          ns = IDLE; nd = '{0, 0, 0, 0};
        end else if (start) begin
          if (door_closed && m_state == ENTRY && reg_nonzero()) begin
            ns = LOAD; nph = 0;
          end
`ifdef QUICK_START_EN
          else if (door_closed && !reg_nonzero()) begin
            ns = LOAD; nph = 0; nd = '{0, 0, 3, 0};
          end
`endif
        end else if (key_valid && key_digit <= 4'd9) begin
          ns = ENTRY; nd = '{m_dig[1], m_dig[2], m_dig[3], int'(key_digit)};
        end
      end
      LOAD: ns = COOK;
      COOK: begin
        if (!door_closed || stop) begin
          ns = PAUSE;
        end else if (timer_zero) begin
          ns = DONE; nph = 0; nb = 0;
        end
`ifdef QUICK_START_EN
        else if (start) begin
          secs = (m_dig[0] * 10 + m_dig[1]) * 60 + ((m_dig[2] > 5) ? 5 : m_dig[2]) * 10 + m_dig[3] + 30;
          if (secs > 5999) secs = 5999;
          mins = secs / 60;
          nd = '{mins / 10, mins % 10, (secs % 60) / 10, secs % 10};
          ns = LOAD;
        end
`endif
        else if (m_ph == TD - 1) begin
          nph = 0; nen = 1'b1;
        end else begin
          nph = m_ph + 1;
        end
      end
      PAUSE: begin
        if (stop) begin
          ns = IDLE; nd = '{0, 0, 0, 0}; nclr = 1'b1;
        end else if (start && door_closed) begin
          ns = COOK;
        end
      end
      DONE: begin
        if (stop || key_valid || !door_closed) begin
          ns = IDLE; nd = '{0, 0, 0, 0};
        end else if (m_ph == TD - 1) begin
          nph = 0;
          if (m_beeps == BC - 1) begin
            ns = IDLE; nd = '{0, 0, 0, 0};
          end else begin
            nb = m_beeps + 1;
          end
        end else begin
          nph = m_ph + 1;
        end
      end
      default: begin
        ns = IDLE; nd = '{0, 0, 0, 0};
      end
    endcase
    tnext = tmr;
    if (!timer_loadn) tnext = bcd_secs(timer_data);
    else if (!timer_clrn) tnext = 0;
    else if (timer_enable && tmr > 0) tnext = tmr - 1;
    @(posedge clock);
    #1;
    m_state = ns; m_dig = nd; m_ph = nph; m_beeps = nb; m_en = nen; m_clr = nclr;
    tmr = tnext;
    timer_zero = (tmr == 0);
    key_valid = 1'b0; start = 1'b0; stop = 1'b0;
    @(negedge clock);
    check_outputs();
  endtask

  task automatic press_key(input int d);
    key_valid = 1'b1; key_digit = 4'(d); cycle();
  endtask
  task automatic press_start();
    start = 1'b1; cycle();
  endtask
  task automatic press_stop();
    stop = 1'b1; cycle();
  endtask

  initial begin
    int nbeep, nen;
    errors = 0; checks = 0;
    clrn = 1'b0; key_valid = 1'b0; key_digit = 4'd0; start = 1'b0; stop = 1'b0;
    door_closed = 1'b1; tmr = 0; timer_zero = 1'b1;
    model_reset();
    repeat (2) @(negedge clock);
    check_outputs();
    chk("rst_state", 16'(state_o), 16'd0);
    chk("rst_loadn", 16'(timer_loadn), 16'd1);
    clrn = 1'b1;

    // Entry of 12:34 and load
    press_key(1); press_key(2); press_key(3); press_key(4);
    chk("t1_data", timer_data, 16'h1234);
    chk("t1_entry", 16'(state_o), 16'd1);
    press_start();
    chk("t1_loadn", 16'(timer_loadn), 16'd0);
    cycle();
    chk("t1_mag", 16'(magnetron_on), 16'd1);
    press_stop(); press_stop();

    // Two-second cook to completion and beep
    press_key(0); press_key(0); press_key(0); press_key(2);
    press_start();
    nbeep = 0; nen = 0;
    repeat (30) begin
      cycle();
      if (beep) nbeep++;
      if (timer_enable) nen++;
    end
    chk("t2_beep_cycles", 16'(nbeep), 16'd12);
    chk("t2_ticks", 16'(nen), 16'd2);
    chk("t2_idle", 16'(state_o), 16'd0);

    // Door opened mid-second, resume keeps partial second
    press_key(0); press_key(0); press_key(0); press_key(5);
    press_start();
    repeat (7) cycle();
    door_closed = 1'b0; cycle();
    chk("t3_pause", 16'(state_o), 16'd4);
    chk("t3_mag_off", 16'(magnetron_on), 16'd0);
    repeat (2) cycle();
    door_closed = 1'b1; press_start();
    chk("t3_resume", 16'(state_o), 16'd3);
    cycle();
    chk("t3_no_tick", 16'(timer_enable), 16'd0);
    cycle();
    chk("t3_tick", 16'(timer_enable), 16'd1);
    press_stop(); press_stop();

    // Saturated seconds display; stop beats start in PAUSE
    press_key(0); press_key(0); press_key(9); press_key(9);
    chk("t4_data", timer_data, 16'h0059);
    press_start(); cycle();
    press_stop();
    stop = 1'b1; start = 1'b1; cycle();
    chk("t4_idle", 16'(state_o), 16'd0);
    chk("t4_clrn", 16'(timer_clrn), 16'd0);
    cycle();
    chk("t4_clrn_end", 16'(timer_clrn), 16'd1);

    // Invalid digit, key during cook, reset mid-cook
    press_key(12);
    chk("t5_bad_key", timer_data, 16'h0000);
    press_key(1); press_start(); cycle();
    press_key(7);
    chk("t5_cook_key", timer_data, 16'h0001);
    cycle();
    clrn = 1'b0;
    #1;
    model_reset(); tmr = 0; timer_zero = 1'b1;
    check_outputs();
    chk("t5_rst_mag", 16'(magnetron_on), 16'd0);
    @(negedge clock);
    clrn = 1'b1;

`ifdef QUICK_START_EN
    press_start();
    chk("t6_quick", timer_data, 16'h0030);
    cycle(); press_stop(); press_stop();
    press_key(4); press_key(5); press_start(); cycle();
    press_start();
    chk("t6_add30", timer_data, 16'h0115);
    chk("t6_loadn", 16'(timer_loadn), 16'd0);
    cycle(); press_stop(); press_stop();
`endif

    // Random strobes and door activity
    for (int i = 0; i < 3000; i++) begin
      key_valid = ($urandom_range(0, 7) == 0);
      key_digit = 4'($urandom_range(0, 15));
      start = ($urandom_range(0, 9) == 0);
      stop = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 24) == 0) door_closed = ~door_closed;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
